// File: rtl/d_sram_assoc_pkg.sv
// Shared definitions for the set-associative D-cache storage array.
// Holds the default geometry (address width, block size, sets, ways),
// the offset/index/tag field widths derived from it, the flush-walk
// FSM state encoding and small helpers for the PLRU and way-index widths.
package d_sram_assoc_pkg;

   localparam int ADDR_SIZE       = 32;
   localparam int BLOCK_BYTES_NUM = 16;
   localparam int BLOCK_SIZE_BITS = BLOCK_BYTES_NUM * 8;
   localparam int SETS_NUM        = 64;
   localparam int WAYS_NUM        = 2;

   localparam int OFFSET_W = $clog2(BLOCK_BYTES_NUM);
   localparam int INDEX_W  = $clog2(SETS_NUM);
   localparam int TAG_W    = ADDR_SIZE - OFFSET_W - INDEX_W;

   // Flush-walk FSM: reset and every accepted flush run through FLUSH.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } flush_state_e;

   // Tree PLRU needs WAYS-1 bits per set; keep at least one bit so the
   // storage stays a legal vector for the direct-mapped case.
   function automatic int plru_bits(input int ways);
      return (ways > 1) ? ways - 1 : 1;
   endfunction

   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/d_sram_assoc_if.sv
// Request/response bundle between the D-cache controller (master) and the
// storage array (slave).
//
// Handshake: a request (en) or a flush command (flush) is accepted on a
// rising clock edge only when ready=1 at that edge. flush wins over en in
// the same cycle. The response (hit, dirtyBit, dataOut, victimAddr,
// victimValid) is valid after the edge following acceptance and holds
// until the next accepted request; hit reads 0 in any cycle that follows
// an edge with no accepted request. flushDone pulses for one cycle when a
// flush walk completes, in the same cycle ready returns to 1.
//
// Ports (master view):
//   en, wen, dmemWen, flush, bytesAccess, addr, dataIn  -> array
//   ready, hit, dirtyBit, dataOut, victimAddr,
//   victimValid, flushDone                               <- array
interface d_sram_assoc_if
   import d_sram_assoc_pkg::*;
#(
   parameter int ADDR_W      = ADDR_SIZE,
   parameter int BLOCK_BYTES = BLOCK_BYTES_NUM
) ();

   logic                     en;
   logic                     wen;
   logic                     dmemWen;
   logic                     flush;
   logic [BLOCK_BYTES-1:0]   bytesAccess;
   logic [ADDR_W-1:0]        addr;
   logic [BLOCK_BYTES*8-1:0] dataIn;

   logic                     ready;
   logic                     hit;
   logic                     dirtyBit;
   logic [BLOCK_BYTES*8-1:0] dataOut;
   logic [ADDR_W-1:0]        victimAddr;
   logic                     victimValid;
   logic                     flushDone;

   modport master (
      output en, wen, dmemWen, flush, bytesAccess, addr, dataIn,
      input  ready, hit, dirtyBit, dataOut, victimAddr, victimValid, flushDone
   );

   modport slave (
      input  en, wen, dmemWen, flush, bytesAccess, addr, dataIn,
      output ready, hit, dirtyBit, dataOut, victimAddr, victimValid, flushDone
   );

endinterface

// File: rtl/d_sram_assoc_plru_tree.sv
// Combinational tree pseudo-LRU for one set.
// Each node bit points toward the half holding the next victim
// (0 = lower-numbered half, 1 = upper half). Touching a way flips every
// node on its path to point away from it.
// Ports:
//   bits_i      current PLRU bits of the set
//   touch_way_i way being accessed
//   victim_o    way the current bits select for replacement
//   bits_o      bits after touching touch_way_i
module d_sram_assoc_plru_tree
   import d_sram_assoc_pkg::*;
#(
   parameter int WAYS = WAYS_NUM,
   localparam int PLRU_W = plru_bits(WAYS),
   localparam int WAY_W  = way_bits(WAYS)
) (
   input  logic [PLRU_W-1:0] bits_i,
   input  logic [WAY_W-1:0]  touch_way_i,
   output logic [WAY_W-1:0]  victim_o,
   output logic [PLRU_W-1:0] bits_o
);

   if (WAYS == 1) begin : g_one
      logic unused_touch;
      assign unused_touch = ^touch_way_i;
      assign victim_o     = '0;
      assign bits_o       = bits_i;
   end else if (WAYS == 2) begin : g_two
      assign victim_o = bits_i[0];
      assign bits_o   = ~touch_way_i[0];
   end else begin : g_four
      // bits[0] = root, bits[1] = ways 0/1 node, bits[2] = ways 2/3 node.
      always_comb begin
         bits_o    = bits_i;
         bits_o[0] = ~touch_way_i[1];
         if (touch_way_i[1]) begin
            bits_o[2] = ~touch_way_i[0];
         end else begin
            bits_o[1] = ~touch_way_i[0];
         end
         victim_o = bits_i[0] ? {1'b1, bits_i[2]} : {1'b0, bits_i[1]};
      end
   end

endmodule

// File: rtl/d_sram_assoc.sv
// Set-associative L1 D-cache storage: tag, valid, dirty, tree-PLRU and
// block data per way, with a one-cycle registered response.
// Reads/writes look up all ways of the indexed set; write hits merge
// byte-enabled data and mark the line dirty; fills load a whole block into
// the matching way (if the tag is present) or the victim way. Misses report
// the victim line for write-back. A flush walks all sets, one per cycle,
// clearing valid, dirty and PLRU state; reset runs the same walk.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        request/response bundle (slave side)
//   dbg_state  flush-walk FSM state
module d_sram_assoc
   import d_sram_assoc_pkg::*;
#(
   parameter int ADDR_W      = ADDR_SIZE,
   parameter int BLOCK_BYTES = BLOCK_BYTES_NUM,
   parameter int SETS        = SETS_NUM,
   parameter int WAYS        = WAYS_NUM
) (
   input  logic           clk,
   input  logic           rst,
   d_sram_assoc_if.slave  bus,
   output flush_state_e   dbg_state
);

   localparam int OFF_W    = $clog2(BLOCK_BYTES);
   localparam int IDX_W    = $clog2(SETS);
   localparam int TAG_BITS = ADDR_W - OFF_W - IDX_W;
   localparam int DATA_W   = BLOCK_BYTES * 8;
   localparam int WAY_W    = way_bits(WAYS);
   localparam int PLRU_W   = plru_bits(WAYS);

   // Tag/data storage is never reset; valid gates every use of it.
   logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0]   data_mem [SETS][WAYS];
   logic [WAYS-1:0]     valid_q  [SETS];
   logic [WAYS-1:0]     dirty_q  [SETS];
   logic [PLRU_W-1:0]   plru_q   [SETS];

   flush_state_e        state_q, state_d;
   logic [IDX_W-1:0]    flush_idx_q, flush_idx_d;
   logic                flush_done_q, flush_done_d;
   logic                hit_q, hit_d;
   logic                dirty_bit_q, dirty_bit_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic [ADDR_W-1:0]   victim_addr_q, victim_addr_d;
   logic                victim_valid_q, victim_valid_d;

   logic [IDX_W-1:0]    req_idx;
   logic [TAG_BITS-1:0] req_tag;
   logic                accept, start_flush;
   logic                hit_any, inv_any;
   logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, victim_way;
   logic [WAY_W-1:0]    fill_way, touch_way;
   logic [PLRU_W-1:0]   plru_next;
   logic [DATA_W-1:0]   merged;
   logic                wr_en, wr_dirty, plru_we;
   logic [WAY_W-1:0]    wr_way;
   logic [DATA_W-1:0]   wr_data;
   logic                unused_offset;

   assign req_idx       = bus.addr[OFF_W +: IDX_W];
   assign req_tag       = bus.addr[ADDR_W-1 -: TAG_BITS];
   assign unused_offset = ^bus.addr[OFF_W-1:0];
   assign accept        = (state_q == ST_IDLE) && bus.en && !bus.flush;
   assign start_flush   = (state_q == ST_IDLE) && bus.flush;

   // Way lookup. Loops run downward so the lowest matching index wins.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[req_idx][w]) begin
            inv_any = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      victim_way = inv_any ? inv_way : plru_victim;
      // A fill to a tag already present reuses that way, never duplicating it.
      fill_way   = hit_any ? hit_way : victim_way;
      touch_way  = bus.dmemWen ? fill_way : hit_way;
   end

   d_sram_assoc_plru_tree #(.WAYS(WAYS)) u_plru (
      .bits_i      (plru_q[req_idx]),
      .touch_way_i (touch_way),
      .victim_o    (plru_victim),
      .bits_o      (plru_next)
   );

   always_comb begin
      merged = data_mem[req_idx][hit_way];
      for (int b = 0; b < BLOCK_BYTES; b++) begin
         if (bus.bytesAccess[b]) begin
            merged[b*8 +: 8] = bus.dataIn[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      flush_idx_d    = flush_idx_q;
      flush_done_d   = 1'b0;
      hit_d          = 1'b0;
      dirty_bit_d    = dirty_bit_q;
      data_out_d     = data_out_q;
      victim_addr_d  = victim_addr_q;
      victim_valid_d = victim_valid_q;
      wr_en          = 1'b0;
      wr_way         = fill_way;
      wr_data        = bus.dataIn;
      wr_dirty       = 1'b0;
      plru_we        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_flush) begin
               state_d     = ST_FLUSH;
               flush_idx_d = '0;
            end else if (accept) begin
               victim_addr_d  = {tag_mem[req_idx][victim_way], req_idx, {OFF_W{1'b0}}};
               victim_valid_d = valid_q[req_idx][victim_way];
               if (bus.dmemWen) begin
                  hit_d       = 1'b1;
                  dirty_bit_d = 1'b0;
                  data_out_d  = bus.dataIn;
                  wr_en       = 1'b1;
                  plru_we     = 1'b1;
               end else if (hit_any) begin
                  hit_d   = 1'b1;
                  plru_we = 1'b1;
                  if (bus.wen) begin
                     wr_en       = 1'b1;
                     wr_way      = hit_way;
                     wr_data     = merged;
                     wr_dirty    = 1'b1;
                     dirty_bit_d = 1'b1;
                     data_out_d  = merged;
                  end else begin
                     dirty_bit_d = dirty_q[req_idx][hit_way];
                     data_out_d  = data_mem[req_idx][hit_way];
                  end
               end else begin
                  // Miss: expose the victim line so the controller can write it back.
                  dirty_bit_d = dirty_q[req_idx][victim_way];
                  data_out_d  = data_mem[req_idx][victim_way];
               end
            end
         end
         ST_FLUSH: begin
            flush_idx_d = flush_idx_q + IDX_W'(1);
            if (flush_idx_q == IDX_W'(SETS - 1)) begin
               state_d      = ST_IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_FLUSH;
         flush_idx_q    <= '0;
         flush_done_q   <= 1'b0;
         hit_q          <= 1'b0;
         dirty_bit_q    <= 1'b0;
         data_out_q     <= '0;
         victim_addr_q  <= '0;
         victim_valid_q <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q        <= state_d;
         flush_idx_q    <= flush_idx_d;
         flush_done_q   <= flush_done_d;
         hit_q          <= hit_d;
         dirty_bit_q    <= dirty_bit_d;
         data_out_q     <= data_out_d;
         victim_addr_q  <= victim_addr_d;
         victim_valid_q <= victim_valid_d;
         if (state_q == ST_FLUSH) begin
            valid_q[flush_idx_q] <= '0;
            dirty_q[flush_idx_q] <= '0;
            plru_q[flush_idx_q]  <= '0;
         end
         if (wr_en) begin
            valid_q[req_idx][wr_way] <= 1'b1;
            dirty_q[req_idx][wr_way] <= wr_dirty;
         end
         if (plru_we) begin
            plru_q[req_idx] <= plru_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[req_idx][wr_way]  <= req_tag;
         data_mem[req_idx][wr_way] <= wr_data;
      end
   end

   assign bus.ready       = (state_q == ST_IDLE);
   assign bus.hit         = hit_q;
   assign bus.dirtyBit    = dirty_bit_q;
   assign bus.dataOut     = data_out_q;
   assign bus.victimAddr  = victim_addr_q;
   assign bus.victimValid = victim_valid_q;
   assign bus.flushDone   = flush_done_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_d_sram_assoc.sv
module tb_d_sram_assoc;
   import d_sram_assoc_pkg::*;

   localparam int BLK_W   = BLOCK_SIZE_BITS;
   localparam int OP_RD   = 0;
   localparam int OP_WR   = 1;
   localparam int OP_FILL = 2;
   localparam int OP_BOTH = 3;

   localparam logic [BLK_W-1:0] D_A5  = {16{8'hA5}};
   localparam logic [BLK_W-1:0] D_11  = {16{8'h11}};
   localparam logic [BLK_W-1:0] D_22  = {16{8'h22}};
   localparam logic [BLK_W-1:0] D_33  = {16{8'h33}};
   localparam logic [BLK_W-1:0] D_44  = {16{8'h44}};
   localparam logic [BLK_W-1:0] D_MRG = {{12{8'hA5}}, {4{8'h11}}};

   // ---------------- clock / reset ----------------
   logic         clk;
   logic         rst;
   flush_state_e dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   d_sram_assoc_if bus ();

   d_sram_assoc dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (true LRU over a recency stamp) ----------------
   logic             m_valid [SETS_NUM][WAYS_NUM];
   logic             m_dirty [SETS_NUM][WAYS_NUM];
   logic [TAG_W-1:0] m_tag   [SETS_NUM][WAYS_NUM];
   logic [BLK_W-1:0] m_data  [SETS_NUM][WAYS_NUM];
   int unsigned      m_stamp [SETS_NUM][WAYS_NUM];
   int unsigned      stamp_ctr;

   logic             e_hit, e_dirty, e_known, e_vvalid;
   logic [BLK_W-1:0] e_data;
   logic [ADDR_SIZE-1:0] e_vaddr;

   task automatic model_clear();
      for (int s = 0; s < SETS_NUM; s++) begin
         for (int w = 0; w < WAYS_NUM; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_tag[s][w]   = '0;
            m_data[s][w]  = '0;
            m_stamp[s][w] = 0;
         end
      end
   endtask

   task automatic model_req(input int op, input logic [ADDR_SIZE-1:0] a,
                            input logic [BLOCK_BYTES_NUM-1:0] be, input logic [BLK_W-1:0] d);
      int s, hw, vw, tw;
      logic [TAG_W-1:0] t;
      s  = int'(a[OFFSET_W +: INDEX_W]);
      t  = a[ADDR_SIZE-1 -: TAG_W];
      hw = -1;
      vw = -1;
      for (int w = 0; w < WAYS_NUM; w++) begin
         if (m_valid[s][w] && m_tag[s][w] == t && hw < 0) hw = w;
         if (!m_valid[s][w] && vw < 0) vw = w;
      end
      if (vw < 0) begin
         vw = 0;
         for (int w = 1; w < WAYS_NUM; w++) if (m_stamp[s][w] < m_stamp[s][vw]) vw = w;
      end
      e_vvalid = m_valid[s][vw];
      e_vaddr  = {m_tag[s][vw], INDEX_W'(s), OFFSET_W'(0)};
      if (op == OP_FILL || op == OP_BOTH) begin
         tw = (hw >= 0) ? hw : vw;
         m_valid[s][tw] = 1'b1;
         m_dirty[s][tw] = 1'b0;
         m_tag[s][tw]   = t;
         m_data[s][tw]  = d;
         m_stamp[s][tw] = ++stamp_ctr;
         e_hit = 1'b1; e_dirty = 1'b0; e_data = d; e_known = 1'b1;
      end else if (hw >= 0) begin
         if (op == OP_WR) begin
            for (int b = 0; b < BLOCK_BYTES_NUM; b++) if (be[b]) m_data[s][hw][b*8 +: 8] = d[b*8 +: 8];
            m_dirty[s][hw] = 1'b1;
         end
         m_stamp[s][hw] = ++stamp_ctr;
         e_hit = 1'b1; e_dirty = m_dirty[s][hw]; e_data = m_data[s][hw]; e_known = 1'b1;
      end else begin
         e_hit = 1'b0; e_dirty = m_dirty[s][vw]; e_data = m_data[s][vw]; e_known = m_valid[s][vw];
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".hit"}, bus.hit, e_hit);
      check({tag, ".dirty"}, bus.dirtyBit, e_dirty);
      if (e_known) check({tag, ".data"}, bus.dataOut, e_data);
      if (!e_hit) begin
         check({tag, ".vvalid"}, bus.victimValid, e_vvalid);
         if (e_vvalid) check({tag, ".vaddr"}, bus.victimAddr, e_vaddr);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_req(input int op, input logic [ADDR_SIZE-1:0] a,
                         input logic [BLOCK_BYTES_NUM-1:0] be, input logic [BLK_W-1:0] d);
      model_req(op, a, be, d);
      bus.en          = 1'b1;
      bus.wen         = (op == OP_WR || op == OP_BOTH);
      bus.dmemWen     = (op == OP_FILL || op == OP_BOTH);
      bus.addr        = a;
      bus.bytesAccess = be;
      bus.dataIn      = d;
      @(posedge clk);
      @(negedge clk);
      bus.en      = 1'b0;
      bus.wen     = 1'b0;
      bus.dmemWen = 1'b0;
   endtask

   task automatic wait_ready(output int lows);
      lows = 0;
      for (int c = 0; c < 400 && !bus.ready; c++) begin
         lows++;
         @(posedge clk);
         @(negedge clk);
      end
      check("ready_timeout", bus.ready, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".ready"}, bus.ready, 1'b0);
      check({tag, ".hit"}, bus.hit, 1'b0);
      check({tag, ".dirty"}, bus.dirtyBit, 1'b0);
      check({tag, ".data"}, bus.dataOut, '0);
      check({tag, ".vaddr"}, bus.victimAddr, '0);
      check({tag, ".vvalid"}, bus.victimValid, 1'b0);
      check({tag, ".fdone"}, bus.flushDone, 1'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int                   op;
      logic [ADDR_SIZE-1:0] a;
      logic [15:0]          be;
      logic [BLK_W-1:0]     d;
      logic                 x_hit;
      logic                 x_dirty;
      logic                 chk_data;
      logic [BLK_W-1:0]     x_data;
      logic                 chk_vic;
      logic                 x_vvalid;
      logic [ADDR_SIZE-1:0] x_vaddr;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int lows;
      logic [ADDR_SIZE-1:0] a;
      int op;

      vecs[0]  = '{OP_RD,   32'h100, 16'h0000, '0,   1'b0, 1'b0, 1'b0, '0,    1'b1, 1'b0, 32'h0};
      vecs[1]  = '{OP_FILL, 32'h100, 16'h0000, D_A5, 1'b1, 1'b0, 1'b1, D_A5,  1'b0, 1'b0, 32'h0};
      vecs[2]  = '{OP_RD,   32'h104, 16'h0000, '0,   1'b1, 1'b0, 1'b1, D_A5,  1'b0, 1'b0, 32'h0};
      vecs[3]  = '{OP_WR,   32'h100, 16'h000F, D_11, 1'b1, 1'b1, 1'b1, D_MRG, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{OP_RD,   32'h100, 16'h0000, '0,   1'b1, 1'b1, 1'b1, D_MRG, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{OP_FILL, 32'h500, 16'h0000, D_22, 1'b1, 1'b0, 1'b1, D_22,  1'b0, 1'b0, 32'h0};
      vecs[6]  = '{OP_RD,   32'h100, 16'h0000, '0,   1'b1, 1'b1, 1'b1, D_MRG, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{OP_RD,   32'h900, 16'h0000, '0,   1'b0, 1'b0, 1'b1, D_22,  1'b1, 1'b1, 32'h500};
      vecs[8]  = '{OP_FILL, 32'h900, 16'h0000, D_33, 1'b1, 1'b0, 1'b1, D_33,  1'b0, 1'b0, 32'h0};
      vecs[9]  = '{OP_RD,   32'h500, 16'h0000, '0,   1'b0, 1'b1, 1'b1, D_MRG, 1'b1, 1'b1, 32'h100};
      vecs[10] = '{OP_RD,   32'h100, 16'h0000, '0,   1'b1, 1'b1, 1'b1, D_MRG, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{OP_RD,   32'h900, 16'h0000, '0,   1'b1, 1'b0, 1'b1, D_33,  1'b0, 1'b0, 32'h0};

      rst = 1'b1;
      bus.en = 1'b0; bus.wen = 1'b0; bus.dmemWen = 1'b0; bus.flush = 1'b0;
      bus.bytesAccess = '0; bus.addr = '0; bus.dataIn = '0;
      stamp_ctr = 0;
      model_clear();

      // Reset state and the reset-triggered walk.
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      check("rst0.state", dbg_state, ST_FLUSH);
      rst = 1'b0;
      wait_ready(lows);
      check("rst0.walk_len", lows, SETS_NUM);
      check("rst0.flush_done", bus.flushDone, 1'b1);

      // Table-driven directed vectors.
      for (int i = 0; i < 12; i++) begin
         do_req(vecs[i].op, vecs[i].a, vecs[i].be, vecs[i].d);
         check($sformatf("vec%0d.hit", i), bus.hit, vecs[i].x_hit);
         check($sformatf("vec%0d.dirty", i), bus.dirtyBit, vecs[i].x_dirty);
         if (vecs[i].chk_data) check($sformatf("vec%0d.data", i), bus.dataOut, vecs[i].x_data);
         if (vecs[i].chk_vic) begin
            check($sformatf("vec%0d.vvalid", i), bus.victimValid, vecs[i].x_vvalid);
            if (vecs[i].x_vvalid) check($sformatf("vec%0d.vaddr", i), bus.victimAddr, vecs[i].x_vaddr);
         end
      end

      // Idle cycle: hit drops, data holds.
      @(posedge clk);
      @(negedge clk);
      check("idle.hit", bus.hit, 1'b0);
      check("idle.data_hold", bus.dataOut, D_33);

      // Flush with a simultaneous request: flush wins; requests and repeat
      // flushes during the walk are ignored (set 0 is already cleared when
      // the stray fill to 0x400 is presented).
      bus.flush = 1'b1; bus.en = 1'b1; bus.addr = 32'h900;
      @(posedge clk);
      @(negedge clk);
      check("flush.hit", bus.hit, 1'b0);
      check("flush.ready", bus.ready, 1'b0);
      check("flush.state", dbg_state, ST_FLUSH);
      bus.dmemWen = 1'b1; bus.addr = 32'h400; bus.dataIn = D_44;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      bus.flush = 1'b0; bus.en = 1'b0; bus.dmemWen = 1'b0;
      wait_ready(lows);
      check("flush.walk_len", lows, SETS_NUM - 3);
      check("flush.done_pulse", bus.flushDone, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("flush.done_single", bus.flushDone, 1'b0);
      model_clear();
      do_req(OP_RD, 32'h100, '0, '0);
      check("postflush.hit", bus.hit, 1'b0);
      check("postflush.vvalid", bus.victimValid, 1'b0);
      check("postflush.dirty", bus.dirtyBit, 1'b0);
      do_req(OP_RD, 32'h400, '0, '0);
      check("postflush.stray_fill", bus.hit, 1'b0);

      // wen and dmemWen together on a miss act as a fill.
      do_req(OP_BOTH, 32'h100, 16'h0001, D_44);
      check("both.hit", bus.hit, 1'b1);
      check("both.dirty", bus.dirtyBit, 1'b0);
      check("both.data", bus.dataOut, D_44);
      do_req(OP_RD, 32'h100, '0, '0);
      check("both.rd_hit", bus.hit, 1'b1);
      check("both.rd_dirty", bus.dirtyBit, 1'b0);
      check("both.rd_data", bus.dataOut, D_44);

      // Reset in the middle of a walk restarts it from set 0.
      bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst1");
      @(negedge clk);
      rst = 1'b0;
      wait_ready(lows);
      check("rst1.walk_len", lows, SETS_NUM);
      model_clear();
      do_req(OP_RD, 32'h100, '0, '0);
      check("rst1.hit", bus.hit, 1'b0);
      check("rst1.vvalid", bus.victimValid, 1'b0);

      // Randomized traffic over two sets and four tags against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            @(posedge clk);
            @(negedge clk);
            check("rnd.idle_hit", bus.hit, 1'b0);
         end else begin
            op = int'($urandom_range(0, 3));
            a  = '0;
            a[ADDR_SIZE-1 -: TAG_W]   = TAG_W'($urandom_range(0, 3));
            a[OFFSET_W +: INDEX_W]    = INDEX_W'($urandom_range(5, 6));
            a[OFFSET_W-1:0]           = OFFSET_W'($urandom_range(0, 15));
            do_req(op, a, 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
            check_model($sformatf("rnd%0d", i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
